input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 155 +++++++++++++++
 tb/tb_input_conditioner.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronize, debounce and classify vending machine button and coin inputs
module input_conditioner #(
    parameter int         DEBOUNCE_TICKS = 16,
    parameter logic [7:0] COIN0_VALUE    = 8'd25,
    parameter logic [7:0] COIN1_VALUE    = 8'd100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] item_btn_raw,
    input  logic [1:0] coin_raw,
    input  logic       cancel_raw,
    input  logic       accept_en,
    output logic       select_pulse,
    output logic [1:0] item_select,
    output logic       coin_pulse,
    output logic [7:0] coin_value,
    output logic       cancel_pulse,
    output logic       error_event,
    output logic       coin_reject
);
    localparam int N  = 7;
    localparam int CW = $clog2(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic [N-1:0]  raw;
    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    logic [N-1:0]  stable;
    logic [N-1:0]  stable_d;
    logic [CW-1:0] cnt [N];
    logic [N-1:0]  press;

    // bit layout: [3:0] items, [5:4] coins, [6] cancel
    assign raw   = {cancel_raw, coin_raw, item_btn_raw};
    assign press = stable & ~stable_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < N; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [3:0] item_ev;
    logic [1:0] coin_ev;
    logic       cancel_ev;
    logic       item_single;
    logic       item_others_held;
    logic [1:0] item_idx;
    logic [1:0] pend;
    logic [1:0] pend_n;
    logic [1:0] coin_req;

    logic       select_n;
    logic [1:0] item_select_n;
    logic       coin_pulse_n;
    logic [7:0] coin_value_n;
    logic       cancel_n;
    logic       error_n;
    logic       reject_n;

    assign item_ev          = press[3:0];
    assign coin_ev          = press[5:4];
    assign cancel_ev        = press[6];
    assign item_single      = (item_ev != 4'd0) && ((item_ev & (item_ev - 4'd1)) == 4'd0);
    assign item_others_held = (stable[3:0] & ~item_ev) != 4'd0;

    always_comb begin
        item_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (item_ev[i]) item_idx = 2'(i);
        end
    end

    always_comb begin
        select_n      = 1'b0;
        item_select_n = item_select;
        cancel_n      = 1'b0;
        error_n       = 1'b0;
        reject_n      = 1'b0;
        coin_pulse_n  = 1'b0;
        coin_value_n  = 8'd0;
        pend_n        = pend;
        coin_req      = pend | (coin_ev & {2{accept_en}});

        // cancel swallows any simultaneous item event without flagging it
        if (cancel_ev) begin
            cancel_n = 1'b1;
        end else if (item_ev != 4'd0) begin
            if (accept_en && item_single && !item_others_held) begin
                select_n      = 1'b1;
                item_select_n = item_idx;
            end else begin
                error_n = 1'b1;
            end
        end

        if ((coin_ev != 2'd0) && !accept_en) begin
            reject_n = 1'b1;
            error_n  = 1'b1;
        end

        // one coin reported per cycle; coin 0 first, the other waits in pend
        if (coin_req[0]) begin
            coin_pulse_n = 1'b1;
            coin_value_n = COIN0_VALUE;
            pend_n[0]    = pend[0] & coin_ev[0] & accept_en;
            pend_n[1]    = coin_req[1];
        end else if (coin_req[1]) begin
            coin_pulse_n = 1'b1;
            coin_value_n = COIN1_VALUE;
            pend_n[0]    = 1'b0;
            pend_n[1]    = pend[1] & coin_ev[1] & accept_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend         <= '0;
            select_pulse <= 1'b0;
            item_select  <= 2'd0;
            coin_pulse   <= 1'b0;
            coin_value   <= 8'd0;
            cancel_pulse <= 1'b0;
            error_event  <= 1'b0;
            coin_reject  <= 1'b0;
        end else begin
            pend         <= pend_n;
            select_pulse <= select_n;
            item_select  <= item_select_n;
            coin_pulse   <= coin_pulse_n;
            coin_value   <= coin_value_n;
            cancel_pulse <= cancel_n;
            error_event  <= error_n;
            coin_reject  <= reject_n;
        end
    end
endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
module tb_input_conditioner;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] item_btn_raw;
    logic [1:0] coin_raw;
    logic       cancel_raw;
    logic       accept_en;
    logic       select_pulse;
    logic [1:0] item_select;
    logic       coin_pulse;
    logic [7:0] coin_value;
    logic       cancel_pulse;
    logic       error_event;
    logic       coin_reject;

    input_conditioner #(.DEBOUNCE_TICKS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .item_btn_raw (item_btn_raw),
        .coin_raw     (coin_raw),
        .cancel_raw   (cancel_raw),
        .accept_en    (accept_en),
        .select_pulse (select_pulse),
        .item_select  (item_select),
        .coin_pulse   (coin_pulse),
        .coin_value   (coin_value),
        .cancel_pulse (cancel_pulse),
        .error_event  (error_event),
        .coin_reject  (coin_reject)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc, sel_cnt, sel_cyc, coin_cnt, cancel_cnt, err_cnt, rej_cnt, bad_cv;
    int cv [2];
    int cc [2];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cyc = 0; sel_cnt = 0; sel_cyc = -1; coin_cnt = 0; cancel_cnt = 0;
        err_cnt = 0; rej_cnt = 0; bad_cv = 0;
        cv[0] = -1; cv[1] = -1; cc[0] = -1; cc[1] = -1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (select_pulse) begin sel_cnt++; sel_cyc = cyc; end
            if (cancel_pulse) cancel_cnt++;
            if (error_event) err_cnt++;
            if (coin_reject) rej_cnt++;
            if (coin_pulse) begin
                if (coin_cnt < 2) begin cv[coin_cnt] = coin_value; cc[coin_cnt] = cyc; end
                coin_cnt++;
            end else if (coin_value != 8'd0) begin
                bad_cv++;
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_sel"}, select_pulse, 0);
        check({tag, "_isel"}, item_select, 0);
        check({tag, "_coin"}, coin_pulse, 0);
        check({tag, "_cval"}, coin_value, 0);
        check({tag, "_cancel"}, cancel_pulse, 0);
        check({tag, "_err"}, error_event, 0);
        check({tag, "_rej"}, coin_reject, 0);
    endtask

    initial begin
        rst_n = 1'b0; item_btn_raw = 4'd0; coin_raw = 2'd0; cancel_raw = 1'b0; accept_en = 1'b1;
        clr();
        step(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        step(3);

        // single item 2: strobe exactly 6 edges after the first sampling edge
        clr(); item_btn_raw = 4'b0100; step(10);
        check("item2_count", sel_cnt, 1);
        check("item2_cycle", sel_cyc, 7);
        check("item2_index", item_select, 2);
        check("item2_err", err_cnt, 0);
        clr(); item_btn_raw = 4'd0; step(10);
        check("release_sel", sel_cnt + err_cnt, 0);

        // 3-cycle glitch is one short of a full debounce
        clr(); item_btn_raw = 4'b0001; step(3); item_btn_raw = 4'd0; step(12);
        check("glitch_sel", sel_cnt, 0);
        check("glitch_err", err_cnt, 0);

        // both coins on the same edge
        clr(); coin_raw = 2'b11; step(12);
        check("coins_count", coin_cnt, 2);
        check("coin0_value", cv[0], 25);
        check("coin0_cycle", cc[0], 7);
        check("coin1_value", cv[1], 100);
        check("coin1_cycle", cc[1], 8);
        check("coins_err", err_cnt, 0);
        coin_raw = 2'd0; step(8);

        // simultaneous multi-press
        clr(); item_btn_raw = 4'b0011; step(10);
        check("multi_err", err_cnt, 1);
        check("multi_sel", sel_cnt, 0);
        check("multi_keep", item_select, 2);
        item_btn_raw = 4'd0; step(8);

        // press while another item is held
        clr(); item_btn_raw = 4'b0010; step(10);
        check("held_first_idx", item_select, 1);
        clr(); item_btn_raw = 4'b1010; step(10);
        check("held_second_err", err_cnt, 1);
        check("held_second_sel", sel_cnt, 0);
        check("held_keep", item_select, 1);
        item_btn_raw = 4'd0; step(8);

        // inputs while disabled
        clr(); accept_en = 1'b0; coin_raw = 2'b10; step(10);
        check("dis_coin_rej", rej_cnt, 1);
        check("dis_coin_err", err_cnt, 1);
        check("dis_coin_pulse", coin_cnt, 0);
        coin_raw = 2'd0; step(8);
        clr(); item_btn_raw = 4'b0001; step(10);
        check("dis_item_err", err_cnt, 1);
        check("dis_item_sel", sel_cnt, 0);
        item_btn_raw = 4'd0; step(8);
        accept_en = 1'b1;

        // cancel beats a simultaneous item
        clr(); cancel_raw = 1'b1; item_btn_raw = 4'b1000; step(10);
        check("cancel_cnt", cancel_cnt, 1);
        check("cancel_sel", sel_cnt, 0);
        check("cancel_err", err_cnt, 0);
        cancel_raw = 1'b0; item_btn_raw = 4'd0; step(8);

        // reset mid-debounce discards the press
        clr(); item_btn_raw = 4'b0001; step(3);
        rst_n = 1'b0; item_btn_raw = 4'd0; step(2);
        check_outputs_zero("midrst");
        rst_n = 1'b1; step(12);
        check("midrst_sel", sel_cnt, 0);

        // reset with coin 1 pending loses it
        clr(); coin_raw = 2'b11; step(7);
        check("pendrst_coin0", cv[0], 25);
        rst_n = 1'b0; coin_raw = 2'd0; step(2);
        rst_n = 1'b1; step(12);
        check("pendrst_count", coin_cnt, 1);

        // button held through reset release
        item_btn_raw = 4'b0010; rst_n = 1'b0; step(2);
        clr(); rst_n = 1'b1; step(10);
        check("heldrst_cycle", sel_cyc, 7);
        check("heldrst_idx", item_select, 1);
        item_btn_raw = 4'd0; step(8);

        check("coin_value_idle", bad_cv, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
